parking_gate_controller: RTL and testbench

- Sequences a single shared barrier gate serving one entry lane and one exit lane of the parking lot.
- Arbitrates between entry and exit requests and drives the gate open/close handshake with a pass sensor.
- Owns the free-space counter `parking_capacity` that feeds the lot's capacity and enable logic.
- Sits between the lane sensors and the gate actuator / display.

---
 rtl/parking_pkg.sv | 39 +++
 rtl/gate_timer.sv | 46 ++++
 rtl/parking_gate_controller.sv | 132 +++++++++++++
 tb/tb_parking_gate_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Module : parking_pkg
// Brief  : Shared state/lane encodings, defaults and lane arbitration helper
//          for the parking gate controller.
// Rev    : 1.0
// ============================================================================
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    OPEN_ENTRY = 2'd1,
    OPEN_EXIT  = 2'd2,
    CLOSE      = 2'd3
  } state_e;

  typedef enum logic {
    ENTRY = 1'b0,
    EXIT  = 1'b1
  } lane_e;

  localparam int DEFAULT_MAX_CAPACITY = 200;
  localparam int DEFAULT_OPEN_TIMEOUT = 32;

  // Round-robin: on a tie the lane not served last time wins.
  function automatic lane_e pick_lane(input logic entry_ok,
                                      input logic exit_ok,
                                      input lane_e last_served);
    if (entry_ok && exit_ok) begin
      return (last_served == EXIT) ? ENTRY : EXIT;
    end else if (entry_ok) begin
      return ENTRY;
    end else begin
      return EXIT;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/gate_timer.sv
`default_nettype none
// ============================================================================
// Module : gate_timer
// Brief  : Counts cycles the gate has been open; flags expiry on the
//          OPEN_TIMEOUT-th open cycle. Used only with GATE_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
module gate_timer
  import parking_pkg::*;
#(
  parameter int OPEN_TIMEOUT = DEFAULT_OPEN_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(OPEN_TIMEOUT + 1);
  localparam logic [CW-1:0] C_LAST = CW'(OPEN_TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign expired = run && (count_q == C_LAST);

  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = '0;
    end else if (run && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/parking_gate_controller.sv
`default_nettype none
// ============================================================================
// Module : parking_gate_controller
// Brief  : Shared entry/exit barrier sequencer with free-space counter.
//          Optional open-gate timeout enabled by defining GATE_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int MAX_CAPACITY = DEFAULT_MAX_CAPACITY,
  parameter int OPEN_TIMEOUT = DEFAULT_OPEN_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic       pass_sensor,
  output logic       gate_open,
  output logic       entry_grant,
  output logic       exit_grant,
  output logic [7:0] parking_capacity,
  output logic       full,
  output logic       empty,
  output logic       busy
);

  localparam logic [7:0] C_CAP_MAX = 8'(MAX_CAPACITY);

  state_e     state_q, state_d;
  lane_e      last_q, last_d;
  logic [7:0] cap_q, cap_d;
  logic       gate_open_q;
  logic       entry_grant_q;
  logic       exit_grant_q;
  logic       entry_ok;
  logic       exit_ok;
  logic       timer_start;
  logic       timeout;

  assign full     = (cap_q == 8'd0);
  assign empty    = (cap_q == C_CAP_MAX);
  assign entry_ok = entry_req && !full;
  assign exit_ok  = exit_req && !empty;

`ifdef GATE_TIMEOUT_EN
  logic in_open;
  assign in_open = (state_q == OPEN_ENTRY) || (state_q == OPEN_EXIT);

  gate_timer #(
    .OPEN_TIMEOUT(OPEN_TIMEOUT)
  ) u_gate_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (timer_start),
    .run    (in_open),
    .expired(timeout)
  );
`else
  logic unused_timeout_cfg;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = (OPEN_TIMEOUT != 0) & timer_start;
`endif

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cap_d       = cap_q;
    timer_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (entry_ok || exit_ok) begin
          timer_start = 1'b1;
          state_d = (pick_lane(entry_ok, exit_ok, last_q) == ENTRY) ? OPEN_ENTRY : OPEN_EXIT;
        end
      end
      OPEN_ENTRY: begin
        // A pass on the expiry cycle still counts the car.
        if (pass_sensor) begin
          state_d = CLOSE;
          last_d  = ENTRY;
          cap_d   = cap_q - 8'd1;
        end else if (timeout) begin
          state_d = CLOSE;
          last_d  = ENTRY;
        end
      end
      OPEN_EXIT: begin
        if (pass_sensor) begin
          state_d = CLOSE;
          last_d  = EXIT;
          cap_d   = cap_q + 8'd1;
        end else if (timeout) begin
          state_d = CLOSE;
          last_d  = EXIT;
        end
      end
      CLOSE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_q        <= EXIT;
      cap_q         <= C_CAP_MAX;
      gate_open_q   <= 1'b0;
      entry_grant_q <= 1'b0;
      exit_grant_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      cap_q         <= cap_d;
      gate_open_q   <= (state_d == OPEN_ENTRY) || (state_d == OPEN_EXIT);
      entry_grant_q <= (state_d == OPEN_ENTRY);
      exit_grant_q  <= (state_d == OPEN_EXIT);
    end
  end

  assign gate_open        = gate_open_q;
  assign entry_grant      = entry_grant_q;
  assign exit_grant       = exit_grant_q;
  assign parking_capacity = cap_q;
  assign busy             = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_parking_gate_controller
// Brief  : Self-checking bench: directed table, corner sequences and random
//          traffic against a transaction-level lot model (two capacities).
// Rev    : 1.0
// ============================================================================
module tb_parking_gate_controller;

  localparam int BIG_MAX   = 200;
  localparam int SMALL_MAX = 2;
  localparam int TIMEOUT   = 32;
`ifdef GATE_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic entry_req = 1'b0;
  logic exit_req = 1'b0;
  logic pass_sensor = 1'b0;

  logic       gate_open_b, entry_grant_b, exit_grant_b, full_b, empty_b, busy_b;
  logic [7:0] cap_b;
  logic       gate_open_s, entry_grant_s, exit_grant_s, full_s, empty_s, busy_s;
  logic [7:0] cap_s;

  always #5 clk = ~clk;

  parking_gate_controller #(.MAX_CAPACITY(BIG_MAX), .OPEN_TIMEOUT(TIMEOUT)) u_dut (
    .clk(clk), .rst_n(rst_n), .entry_req(entry_req), .exit_req(exit_req),
    .pass_sensor(pass_sensor), .gate_open(gate_open_b), .entry_grant(entry_grant_b),
    .exit_grant(exit_grant_b), .parking_capacity(cap_b), .full(full_b),
    .empty(empty_b), .busy(busy_b)
  );

  parking_gate_controller #(.MAX_CAPACITY(SMALL_MAX), .OPEN_TIMEOUT(TIMEOUT)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .entry_req(entry_req), .exit_req(exit_req),
    .pass_sensor(pass_sensor), .gate_open(gate_open_s), .entry_grant(entry_grant_s),
    .exit_grant(exit_grant_s), .parking_capacity(cap_s), .full(full_s),
    .empty(empty_s), .busy(busy_s)
  );

  logic [13:0] out_b, out_s;
  assign out_b = {gate_open_b, entry_grant_b, exit_grant_b, cap_b, full_b, empty_b, busy_b};
  assign out_s = {gate_open_s, entry_grant_s, exit_grant_s, cap_s, full_s, empty_s, busy_s};

  int n_cmp = 0;
  int n_err = 0;

  // Lot model: which lane (if any) holds the gate, a one-cycle cooldown,
  // and the free-space count.
  int m_max[2];
  int m_cap[2];
  bit m_serving[2];
  bit m_lane[2];
  bit m_cool[2];
  bit m_last[2];
  int m_opened[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input bit r, input bit e, input bit x, input bit p);
    bit eo, xo;
    if (!r) begin
      m_cap[i] = m_max[i];
      m_serving[i] = 1'b0;
      m_cool[i] = 1'b0;
      m_last[i] = 1'b1;
      m_opened[i] = 0;
    end else if (m_cool[i]) begin
      m_cool[i] = 1'b0;
    end else if (m_serving[i]) begin
      m_opened[i] = m_opened[i] + 1;
      if (p) begin
        m_cap[i] = m_cap[i] + (m_lane[i] ? 1 : -1);
        m_serving[i] = 1'b0;
        m_cool[i] = 1'b1;
        m_last[i] = m_lane[i];
      end else if (TIMEOUT_EN && m_opened[i] >= TIMEOUT) begin
        m_serving[i] = 1'b0;
        m_cool[i] = 1'b1;
        m_last[i] = m_lane[i];
      end
    end else begin
      eo = e && (m_cap[i] > 0);
      xo = x && (m_cap[i] < m_max[i]);
      if (eo || xo) begin
        m_serving[i] = 1'b1;
        m_opened[i] = 0;
        m_lane[i] = (eo && xo) ? !m_last[i] : xo;
      end
    end
  endtask

  function automatic logic [13:0] model_out(input int i);
    logic [7:0] c;
    c = 8'(m_cap[i]);
    return {m_serving[i], m_serving[i] && !m_lane[i], m_serving[i] && m_lane[i], c,
            m_cap[i] == 0, m_cap[i] == m_max[i], m_serving[i] || m_cool[i]};
  endfunction

  task automatic cycle(input bit r, input bit e, input bit x, input bit p);
    rst_n = r;
    entry_req = e;
    exit_req = x;
    pass_sensor = p;
    @(posedge clk);
    model_step(0, r, e, x, p);
    model_step(1, r, e, x, p);
    #1;
    check("model_big", 32'(out_b), 32'(model_out(0)));
    check("model_small", 32'(out_s), 32'(model_out(1)));
  endtask

  typedef struct {
    bit r, e, x, p;
    bit gate, eg, xg;
    logic [7:0] cap;
    bit full, empty, busy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lane;
    int rr_exp[3];
    int open_cnt;
    m_max[0] = BIG_MAX;
    m_max[1] = SMALL_MAX;
    for (int i = 0; i < 2; i++) model_step(i, 1'b0, 1'b0, 1'b0, 1'b0);

    //            r  e  x  p  gate eg xg cap     full empty busy
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 8'd200, 0, 1, 0};
    tbl[1]  = '{1, 1, 0, 0, 1, 1, 0, 8'd200, 0, 1, 1};
    tbl[2]  = '{1, 0, 0, 0, 1, 1, 0, 8'd200, 0, 1, 1};
    tbl[3]  = '{1, 0, 0, 0, 1, 1, 0, 8'd200, 0, 1, 1};
    tbl[4]  = '{1, 0, 0, 1, 0, 0, 0, 8'd199, 0, 0, 1};
    tbl[5]  = '{1, 0, 0, 0, 0, 0, 0, 8'd199, 0, 0, 0};
    tbl[6]  = '{1, 0, 1, 0, 1, 0, 1, 8'd199, 0, 0, 1};
    tbl[7]  = '{1, 1, 0, 0, 1, 0, 1, 8'd199, 0, 0, 1};
    tbl[8]  = '{1, 1, 0, 1, 0, 0, 0, 8'd200, 0, 1, 1};
    tbl[9]  = '{1, 1, 0, 0, 0, 0, 0, 8'd200, 0, 1, 0};
    tbl[10] = '{1, 0, 1, 0, 0, 0, 0, 8'd200, 0, 1, 0};
    tbl[11] = '{1, 1, 1, 0, 1, 1, 0, 8'd200, 0, 1, 1};
    tbl[12] = '{1, 0, 0, 1, 0, 0, 0, 8'd199, 0, 0, 1};
    tbl[13] = '{1, 0, 0, 0, 0, 0, 0, 8'd199, 0, 0, 0};

    @(negedge clk);
    for (int k = 0; k < 14; k++) begin
      cycle(tbl[k].r, tbl[k].e, tbl[k].x, tbl[k].p);
      check($sformatf("table[%0d]", k), 32'(out_b),
            32'({tbl[k].gate, tbl[k].eg, tbl[k].xg, tbl[k].cap, tbl[k].full, tbl[k].empty, tbl[k].busy}));
    end

    // Fill the small lot, then show a held entry is refused while full.
    cycle(0, 0, 0, 0);
    for (int n = 0; n < 2; n++) begin
      cycle(1, 1, 0, 0);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 1);
      cycle(1, 0, 0, 0);
    end
    check("small_full_cap", 32'(cap_s), 32'd0);
    check("small_full_flag", 32'(full_s), 32'd1);
    for (int n = 0; n < 10; n++) begin
      cycle(1, 1, 0, 0);
      check("small_full_no_grant", 32'({gate_open_s, entry_grant_s, busy_s}), 32'd0);
    end
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 0);
    check("small_exit_grant", 32'({gate_open_s, exit_grant_s}), 32'd3);
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 0);
    check("small_after_exit_cap", 32'(cap_s), 32'd1);

    // Both lanes held: big lot last served exit, so entry, exit, entry.
    rr_exp = '{0, 1, 0};
    for (int n = 0; n < 3; n++) begin
      cycle(1, 1, 1, 0);
      lane = exit_grant_b ? 1 : (entry_grant_b ? 0 : 2);
      check($sformatf("rr_lane[%0d]", n), 32'(lane), 32'(rr_exp[n]));
      cycle(1, 1, 1, 1);
      cycle(1, 1, 1, 0);
    end
    check("rr_final_cap", 32'(cap_b), 32'd197);

    // Reset while the exit gate is open.
    cycle(1, 0, 1, 0);
    check("pre_reset_exit_open", 32'({gate_open_b, exit_grant_b, cap_b}), 32'({2'b11, 8'd197}));
    cycle(0, 0, 0, 0);
    check("reset_abort", 32'(out_b), 32'({3'b000, 8'd200, 3'b010}));

    // Empty lot: exit alone ignored, entry alongside it served.
    cycle(1, 0, 1, 0);
    check("empty_exit_ignored", 32'({busy_b, gate_open_b, exit_grant_b}), 32'd0);
    cycle(1, 1, 1, 0);
    check("empty_entry_served", 32'({gate_open_b, entry_grant_b, exit_grant_b}), 32'b110);
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 0);

`ifdef GATE_TIMEOUT_EN
    cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 0);
    open_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (gate_open_b) open_cnt++;
      cycle(1, 0, 0, 0);
    end
    check("timeout_open_cycles", 32'(open_cnt), 32'(TIMEOUT));
    check("timeout_cap", 32'(cap_b), 32'd200);
    cycle(1, 1, 0, 0);
    for (int n = 0; n < TIMEOUT - 1; n++) cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);
    check("timeout_pass_wins", 32'(cap_b), 32'd199);
`else
    open_cnt = 0;
`endif

    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(199) != 0, $urandom_range(2) == 0,
            $urandom_range(2) == 0, $urandom_range(3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
